// File: rtl/data_sram_axi_bridge_if.sv
// ============================================================================
//  Module   : data_sram_axi_bridge_if
//  Purpose  : CPU data-SRAM port plus single-beat AXI4 read/write channels.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface data_sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU data-SRAM side
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              stallreq;

    // AXI read address / data
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    // AXI write address / data / response
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    // The bridge: slave to the core, master on AXI
    modport master (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq,
        output arid, araddr, arsize, arvalid,
        input  arready,
        input  rdata, rvalid,
        output rready,
        output awid, awaddr, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    // Everything around the bridge: the core and the AXI interconnect
    modport slave (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq,
        input  arid, araddr, arsize, arvalid,
        output arready,
        output rdata, rvalid,
        input  rready,
        input  awid, awaddr, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

`default_nettype wire

// File: rtl/data_sram_axi_bridge.sv
// ============================================================================
//  Module   : data_sram_axi_bridge
//  Purpose  : Turns each data-SRAM request into one single-beat AXI4 read or
//             write, stalling the pipeline until the transaction completes.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input wire                     clk,
    input wire                     rst,
    data_sram_axi_bridge_if.master bus
);

    localparam logic [2:0] c_axi_size = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_AR   = 3'd1,
        RD_R    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_aw_done;
    logic              r_w_done;

    logic              w_accept;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_fin;
    logic              w_w_fin;

    logic              w_stallreq;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_bready;

    assign w_accept = (r_state == IDLE) && bus.data_sram_en;

    // AW and W complete independently; the phase ends once both are done
    assign w_aw_hs  = (r_state == WR_AW_W) && !r_aw_done && bus.awready;
    assign w_w_hs   = (r_state == WR_AW_W) && !r_w_done  && bus.wready;
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done  || w_w_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stallreq  = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.data_sram_en) begin
                    w_stallreq  = 1'b1;
                    w_state_nxt = (bus.data_sram_wen == 4'b0000) ? RD_AR : WR_AW_W;
                end
            end
            RD_AR: begin
                w_stallreq = 1'b1;
                w_arvalid  = 1'b1;
                if (bus.arready) begin
                    w_state_nxt = RD_R;
                end
            end
            RD_R: begin
                w_stallreq = 1'b1;
                w_rready   = 1'b1;
                if (bus.rvalid) begin
                    w_state_nxt = DONE;
                end
            end
            WR_AW_W: begin
                w_stallreq = 1'b1;
                w_awvalid  = !r_aw_done;
                w_wvalid   = !r_w_done;
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt = WR_B;
                end
            end
            WR_B: begin
                w_stallreq = 1'b1;
                w_bready   = 1'b1;
                if (bus.bvalid) begin
                    w_state_nxt = DONE;
                end
            end
            // en seen here still belongs to the finished access
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wen     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= bus.data_sram_addr;
                r_wen     <= bus.data_sram_wen;
                r_wdata   <= bus.data_sram_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if ((r_state == RD_R) && bus.rvalid) begin
                r_rdata <= bus.rdata;
            end
        end
    end

    assign bus.stallreq        = w_stallreq;
    assign bus.data_sram_rdata = r_rdata;

    assign bus.arid    = AXI_ID;
    assign bus.arsize  = c_axi_size;
    assign bus.araddr  = r_addr;
    assign bus.arvalid = w_arvalid;
    assign bus.rready  = w_rready;

    assign bus.awid    = AXI_ID;
    assign bus.awsize  = c_axi_size;
    assign bus.awaddr  = r_addr;
    assign bus.awvalid = w_awvalid;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wen;
    assign bus.wvalid  = w_wvalid;
    assign bus.bready  = w_bready;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_axi_bridge.sv
// ============================================================================
//  Module   : tb_data_sram_axi_bridge
//  Purpose  : Directed and randomized accesses against an AXI slave model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_sram_axi_bridge;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Slave response delays (cycles of waiting before ready/valid)
    int   ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] ar_log[$];
    logic [67:0] w_log[$];      // {addr, data, strb} per completed write

    data_sram_axi_bridge_if bus ();

    data_sram_axi_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drop_en();
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'h0;
    endtask

    // AXI slave: readies/valids are decided at the falling edge
    initial begin : axi_slave
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit rd_pend, aw_tk, w_tk;
        logic [31:0] rd_a, wa, wd;
        logic [3:0]  ws;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; aw_tk = 0; w_tk = 0;
        rd_a = '0; wa = '0; wd = '0; ws = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        forever begin
            @(negedge clk);
            bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            if (rst) begin
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                rd_pend = 0; aw_tk = 0; w_tk = 0;
            end else begin
                if (bus.arvalid && !rd_pend) begin
                    if (ar_cnt >= ar_dly) begin
                        bus.arready = 1; rd_a = bus.araddr; ar_log.push_back(bus.araddr);
                        rd_pend = 1; ar_cnt = 0; r_cnt = 0;
                    end else ar_cnt++;
                end else if (rd_pend && bus.rready) begin
                    if (r_cnt >= r_dly) begin
                        bus.rvalid = 1; bus.rdata = mem_word(rd_a); rd_pend = 0;
                    end else r_cnt++;
                end
                if (bus.awvalid && !aw_tk) begin
                    if (aw_cnt >= aw_dly) begin
                        bus.awready = 1; wa = bus.awaddr; aw_tk = 1; aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (bus.wvalid && !w_tk) begin
                    if (w_cnt >= w_dly) begin
                        bus.wready = 1; wd = bus.wdata; ws = bus.wstrb; w_tk = 1; w_cnt = 0;
                    end else w_cnt++;
                end
                if (aw_tk && w_tk && bus.bready) begin
                    if (b_cnt >= b_dly) begin
                        bus.bvalid = 1; w_log.push_back({wa, wd, ws});
                        aw_tk = 0; w_tk = 0; b_cnt = 0;
                    end else b_cnt++;
                end
            end
        end
    end

    // Pending valids/readies must hold, with stable payload, until their handshake
    initial begin : protocol_monitor
        logic p_ar, p_arr, p_aw, p_awr, p_w, p_wr, p_rr, p_rv, p_br, p_bv;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        p_ar = 0; p_arr = 0; p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0;
        p_rr = 0; p_rv = 0; p_br = 0; p_bv = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (p_ar && !p_arr) check("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
                if (p_aw && !p_awr) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
                if (p_w && !p_wr)   check("w_hold", {bus.wvalid, bus.wstrb, bus.wdata}, {1'b1, p_wstrb, p_wdata});
                if (p_rr && !p_rv)  check("rready_hold", bus.rready, 1);
                if (p_br && !p_bv)  check("bready_hold", bus.bready, 1);
            end
            p_ar  = bus.arvalid && !rst; p_arr = bus.arready; p_araddr = bus.araddr;
            p_aw  = bus.awvalid && !rst; p_awr = bus.awready; p_awaddr = bus.awaddr;
            p_w   = bus.wvalid  && !rst; p_wr  = bus.wready;  p_wdata = bus.wdata; p_wstrb = bus.wstrb;
            p_rr  = bus.rready  && !rst; p_rv  = bus.rvalid;
            p_br  = bus.bready  && !rst; p_bv  = bus.bvalid;
        end
    end

    // One access from request cycle to DONE; returns in DONE with en still held.
    // Reads: d1=AR wait, d2=R wait. Writes: d1=AW wait, d2=W wait, d3=B wait.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input int d1, input int d2, input int d3, inout logic [31:0] exp_rdata);
        bit is_rd;
        int ph1, ph2, total;
        logic [5:0] exp_v;
        is_rd  = (wen == 4'h0);
        ar_dly = d1; r_dly = d2; aw_dly = d1; w_dly = d2; b_dly = d3;
        ph1    = is_rd ? d1 + 1 : ((d1 > d2) ? d1 : d2) + 1;
        ph2    = is_rd ? d2 + 1 : d3 + 1;
        total  = 1 + ph1 + ph2;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        #1;
        check("req_stall", bus.stallreq, 1);
        for (int k = 1; k <= total; k++) begin
            next_cycle();
            if (k == total)   exp_v = 6'b000000;
            else if (k <= ph1) exp_v = is_rd ? 6'b110000 : {1'b1, 2'b00, (k - 1 <= d1), (k - 1 <= d2), 1'b0};
            else              exp_v = is_rd ? 6'b101000 : 6'b100001;
            check("cycle_ctl", {bus.stallreq, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, exp_v);
            if (k == 1 && is_rd)
                check("ar_fields", {bus.arid, bus.arsize, bus.araddr}, {4'd1, 3'b010, addr});
            if (k == 1 && !is_rd)
                check("aw_fields", {bus.awid, bus.awsize, bus.awaddr, bus.wstrb, bus.wdata},
                      {4'd1, 3'b010, addr, wen, wdata});
        end
        if (is_rd) exp_rdata = mem_word(addr);
        check("rdata", bus.data_sram_rdata, exp_rdata);
        check("ar_count", ar_log.size(), is_rd ? 1 : 0);
        check("wr_count", w_log.size(), is_rd ? 0 : 1);
        if (is_rd && ar_log.size() > 0) check("ar_addr", ar_log[0], addr);
        if (!is_rd && w_log.size() > 0) check("wr_txn", w_log[0], {addr, wdata, wen});
        ar_log.delete();
        w_log.delete();
    endtask

    initial begin : stim
        logic [31:0] exp_rdata;
        logic [3:0]  rw;
        logic [31:0] ra, rd;
        exp_rdata = '0;
        rst = 1'b1;
        bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
        bus.data_sram_addr = '0; bus.data_sram_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ctl", {bus.stallreq, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 6'b0);
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        rst = 1'b0;
        next_cycle();

        // 0-wait read
        access(4'h0, 32'h0000_1000, 32'h0, 0, 0, 0, exp_rdata);
        next_cycle(); drop_en();
        repeat (2) next_cycle();
        check("rdata_held", bus.data_sram_rdata, 32'hDEAD_BEEF);
        check("idle_no_ar", ar_log.size(), 0);

        // partial store, AW accepted two cycles before W
        access(4'b0011, 32'h0000_1008, 32'h0000_ABCD, 0, 2, 0, exp_rdata);
        next_cycle(); drop_en();
        next_cycle();

        // slow read
        access(4'h0, 32'h0000_1010, 32'h0, 5, 3, 0, exp_rdata);
        next_cycle(); drop_en();
        next_cycle();

        // back-to-back read then write
        access(4'h0, 32'h0000_2000, 32'h0, 0, 0, 0, exp_rdata);
        next_cycle();
        access(4'hF, 32'h0000_2004, 32'h1234_5678, 0, 0, 0, exp_rdata);
        next_cycle(); drop_en();
        next_cycle();

        // AW and W in the same cycle, delayed B
        access(4'hF, 32'h0000_2008, 32'hCAFE_F00D, 1, 1, 2, exp_rdata);
        next_cycle(); drop_en();
        next_cycle();

        // reset pulse while waiting in RD_R
        ar_dly = 0; r_dly = 6;
        bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'h0; bus.data_sram_addr = 32'h0000_3000;
        next_cycle();
        next_cycle();
        check("pre_rst_ctl", {bus.stallreq, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 6'b101000);
        rst = 1'b1;
        drop_en();
        #1;
        check("async_rst_ctl", {bus.stallreq, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 6'b0);
        check("async_rst_rdata", bus.data_sram_rdata, 32'h0);
        exp_rdata = '0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        ar_log.delete();
        w_log.delete();
        next_cycle();
        access(4'h0, 32'h0000_3004, 32'h0, 0, 0, 0, exp_rdata);
        next_cycle(); drop_en();
        next_cycle();

        // randomized mix of reads, full and partial stores, delays and gaps
        for (int i = 0; i < 24; i++) begin
            rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ra = $urandom();
            ra[1:0] = 2'b00;
            rd = $urandom();
            access(rw, ra, rd, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), exp_rdata);
            next_cycle();
            if ($urandom_range(0, 1) == 1) begin
                drop_en();
                next_cycle();
            end
        end
        drop_en();
        repeat (3) next_cycle();
        check("final_quiet", {bus.stallreq, bus.arvalid, bus.awvalid, bus.wvalid}, 4'b0);
        check("final_logs", ar_log.size() + w_log.size(), 0);
        check("final_rdata", bus.data_sram_rdata, exp_rdata);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
